// File: rtl/fifo_stream_pkg.sv
// Shared definitions for the FIFO read-side stream adapter:
// the skid buffer occupancy encoding, the fixed skid depth and the
// default word width.
package fifo_stream_pkg;

    localparam int SKID_DEPTH     = 2;
    localparam int DATA_WIDTH_DEF = 12;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry register skid buffer. The head register drives the stream data
// directly; the tail only fills while the head is stalled. Flush empties the
// buffer and wins over a simultaneous push or pop.
module fifo_skid_buf
    import fifo_stream_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  flush_i,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic [DATA_WIDTH-1:0] din_i,
    output logic [DATA_WIDTH-1:0] dout_o,
    output logic                  valid_o,
    output occ_e                  occ_o
);

    occ_e                  occ_q, occ_d;
    logic                  valid_q;
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] tail_q, tail_d;

    // State register: occupancy plus a registered copy of "not empty".
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            occ_q   <= OCC_EMPTY;
            valid_q <= 1'b0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            occ_q   <= occ_d;
            valid_q <= (occ_d != OCC_EMPTY);
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    // Next occupancy from push/pop, with flush overriding both.
    always_comb begin
        occ_d = occ_q;
        if (flush_i) begin
            occ_d = OCC_EMPTY;
        end else begin
            case (occ_q)
                OCC_EMPTY: if (push_i) occ_d = OCC_ONE;
                OCC_ONE: begin
                    if (push_i && !pop_i)      occ_d = OCC_TWO;
                    else if (!push_i && pop_i) occ_d = OCC_EMPTY;
                end
                OCC_TWO:   if (pop_i && !push_i) occ_d = OCC_ONE;
                default:   occ_d = OCC_EMPTY;
            endcase
        end
    end

    // Data movement: the head changes only on pop or on a push into an empty buffer.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        if (!flush_i) begin
            case (occ_q)
                OCC_EMPTY: if (push_i) head_d = din_i;
                OCC_ONE: begin
                    if (push_i && pop_i) head_d = din_i;
                    else if (push_i)     tail_d = din_i;
                end
                OCC_TWO: begin
                    if (pop_i) begin
                        head_d = tail_q;
                        if (push_i) tail_d = din_i;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dout_o  = head_q;
    assign valid_o = valid_q;
    assign occ_o   = occ_q;

    // The read-issue logic upstream must never deliver a word into a full buffer.
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        !(occ_q == OCC_TWO && push_i && !pop_i && !flush_i));

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side consumer for the asynchronous FIFO: issues FIFO reads only when
// the word returning next cycle is guaranteed a slot, and presents the words
// as a valid/ready stream through a 2-entry skid buffer.
// Optional statistics counters are enabled by defining FIFO_RD_STREAM_STATS_EN.
module fifo_rd_stream
    import fifo_stream_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int SKID_DEPTH = fifo_stream_pkg::SKID_DEPTH
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  fifo_empty_i,
    input  logic [DATA_WIDTH-1:0] fifo_rdata_i,
    input  logic                  fifo_underflow_i,
    output logic                  fifo_rd_en_o,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [DATA_WIDTH-1:0] m_data_o,
    input  logic                  flush_i,
    output logic                  err_underflow_o
`ifdef FIFO_RD_STREAM_STATS_EN
    ,
    output logic [31:0]           stat_words_o,
    output logic [31:0]           stat_stall_o
`endif
);

    if (SKID_DEPTH != 2) begin : g_bad_skid_depth
        $error("fifo_rd_stream: SKID_DEPTH must be 2");
    end

    occ_e       occ;
    logic       pop;
    logic [2:0] demand;
    logic       inflight_q, inflight_d;
    logic       err_q, err_d;

    assign pop = m_valid_o & m_ready_i;

    // Words held plus the word on its way, after this cycle's pop.
    assign demand = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};

    assign fifo_rd_en_o = rst_n_i & !fifo_empty_i & !flush_i & (demand < 3'd2);
    assign inflight_d   = fifo_rd_en_o;
    assign err_d        = err_q | fifo_underflow_i;

    // Track the outstanding read and the sticky underflow flag.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            inflight_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
            err_q      <= err_d;
        end
    end

    assign err_underflow_o = err_q;

    fifo_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .flush_i (flush_i),
        .push_i  (inflight_q),
        .pop_i   (pop),
        .din_i   (fifo_rdata_i),
        .dout_o  (m_data_o),
        .valid_o (m_valid_o),
        .occ_o   (occ)
    );

`ifdef FIFO_RD_STREAM_STATS_EN
    logic [31:0] words_q, words_d;
    logic [31:0] stall_q, stall_d;

    assign words_d = words_q + {31'd0, pop};
    assign stall_d = stall_q + {31'd0, m_valid_o & !m_ready_i};

    // Free-running transfer and stall counters; flush leaves them alone.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            words_q <= '0;
            stall_q <= '0;
        end else begin
            words_q <= words_d;
            stall_q <= stall_d;
        end
    end

    assign stat_words_o = words_q;
    assign stat_stall_o = stall_q;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream with a behavioural registered-read FIFO.
module tb_fifo_rd_stream;

    localparam int DW = 12;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          fifo_empty_i;
    logic [DW-1:0] fifo_rdata_i;
    logic          fifo_underflow_i;
    logic          fifo_rd_en_o;
    logic          m_valid_o;
    logic          m_ready_i;
    logic [DW-1:0] m_data_o;
    logic          flush_i;
    logic          err_underflow_o;
`ifdef FIFO_RD_STREAM_STATS_EN
    logic [31:0]   stat_words_o;
    logic [31:0]   stat_stall_o;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // FIFO model storage: wr_ptr owned by the main initial, rd_ptr by the model.
    logic [DW-1:0] fmem [0:63];
    int wr_ptr    = 0;
    int rd_ptr    = 0;
    int bad_reads = 0;

    // Stream monitor state (owned by the monitor process).
    int            rd_cnt  = 0;
    int            held    = 0;
    int            ovf_cnt = 0;
    logic [DW-1:0] got_q [$];

    always #5 clk = ~clk;

    assign fifo_empty_i = (rd_ptr == wr_ptr);

    fifo_rd_stream #(.DATA_WIDTH(DW)) dut (
        .clk_i            (clk),
        .rst_n_i          (rst_n),
        .fifo_empty_i     (fifo_empty_i),
        .fifo_rdata_i     (fifo_rdata_i),
        .fifo_underflow_i (fifo_underflow_i),
        .fifo_rd_en_o     (fifo_rd_en_o),
        .m_valid_o        (m_valid_o),
        .m_ready_i        (m_ready_i),
        .m_data_o         (m_data_o),
        .flush_i          (flush_i),
`ifdef FIFO_RD_STREAM_STATS_EN
        .stat_words_o     (stat_words_o),
        .stat_stall_o     (stat_stall_o),
`endif
        .err_underflow_o  (err_underflow_o)
    );

    // Registered-read FIFO: data appears the cycle after an accepted read.
    initial begin
        fifo_rdata_i = '0;
        forever begin
            @(posedge clk);
            if (fifo_rd_en_o) begin
                if (rd_ptr == wr_ptr) begin
                    bad_reads++;
                end else begin
                    fifo_rdata_i <= fmem[rd_ptr % 64];
                    rd_ptr       <= rd_ptr + 1;
                end
            end
        end
    end

    // Monitor: counts reads, logs transfers, tracks words held + in flight.
    initial begin
        forever begin
            @(negedge clk);
            if (fifo_rd_en_o) rd_cnt++;
            if (m_valid_o && m_ready_i) begin
                got_q.push_back(m_data_o);
                $display("pop #%0d data=%h", got_q.size(), m_data_o);
            end
            if (!rst_n || flush_i) held = 0;
            else held = held + (fifo_rd_en_o ? 1 : 0) - ((m_valid_o && m_ready_i) ? 1 : 0);
            if (held > 2) ovf_cnt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [DW-1:0] w);
        fmem[wr_ptr % 64] = w;
        wr_ptr++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; m_ready_i = 1'b1; flush_i = 1'b0; fifo_underflow_i = 1'b0;
        load(12'h111);
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++; if (fifo_rd_en_o !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %b want 0", fifo_rd_en_o); end
            n_checks++; if (m_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", m_valid_o); end
            n_checks++; if (m_data_o !== 12'h000) begin n_fail++; $display("FAIL reset_data: got %h want 000", m_data_o); end
            n_checks++; if (err_underflow_o !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err_underflow_o); end
        end
`ifdef FIFO_RD_STREAM_STATS_EN
        n_checks++; if (stat_words_o !== 32'd0) begin n_fail++; $display("FAIL reset_stat_words: got %0d want 0", stat_words_o); end
        n_checks++; if (stat_stall_o !== 32'd0) begin n_fail++; $display("FAIL reset_stat_stall: got %0d want 0", stat_stall_o); end
`endif
        wr_ptr = rd_ptr;  // the FIFO shares this reset, so its contents are gone
        rst_n = 1'b1;
        tick();
        n_checks++; if (m_valid_o !== 1'b0) begin n_fail++; $display("FAIL post_reset_valid: got %b want 0", m_valid_o); end
        $display("test_reset done");
    endtask

    task automatic test_single_word();
        int r0 = rd_cnt;
        m_ready_i = 1'b1;
        load(12'h5A3);
        #1;
        n_checks++; if (fifo_rd_en_o !== 1'b1) begin n_fail++; $display("FAIL single_rd_en_N: got %b want 1", fifo_rd_en_o); end
        tick();
        n_checks++; if (fifo_rd_en_o !== 1'b0) begin n_fail++; $display("FAIL single_rd_en_N1: got %b want 0", fifo_rd_en_o); end
        n_checks++; if (m_valid_o !== 1'b0) begin n_fail++; $display("FAIL single_valid_N1: got %b want 0", m_valid_o); end
        tick();
        n_checks++; if (m_valid_o !== 1'b1) begin n_fail++; $display("FAIL single_valid_N2: got %b want 1", m_valid_o); end
        n_checks++; if (m_data_o !== 12'h5A3) begin n_fail++; $display("FAIL single_data: got %h want 5a3", m_data_o); end
        tick();
        n_checks++; if (m_valid_o !== 1'b0) begin n_fail++; $display("FAIL single_valid_N3: got %b want 0", m_valid_o); end
        tick();
        n_checks++; if (rd_cnt - r0 !== 1) begin n_fail++; $display("FAIL single_rd_pulses: got %0d want 1", rd_cnt - r0); end
        $display("test_single_word done");
    endtask

    task automatic test_stream();
        int r0   = rd_cnt;
        int base = got_q.size();
        m_ready_i = 1'b1;
        for (int i = 0; i < 16; i++) load(12'h100 + 12'(i));
        tick();
        tick();
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (m_valid_o !== 1'b1 || m_data_o !== 12'h100 + 12'(i)) begin
                n_fail++; $display("FAIL stream_word%0d: got v=%b d=%h want v=1 d=%h", i, m_valid_o, m_data_o, 12'h100 + 12'(i));
            end
            tick();
        end
        n_checks++; if (m_valid_o !== 1'b0) begin n_fail++; $display("FAIL stream_end_valid: got %b want 0", m_valid_o); end
        n_checks++; if (rd_cnt - r0 !== 16) begin n_fail++; $display("FAIL stream_rd_pulses: got %0d want 16", rd_cnt - r0); end
        n_checks++; if (got_q.size() - base !== 16) begin n_fail++; $display("FAIL stream_count: got %0d want 16", got_q.size() - base); end
        $display("test_stream done");
    endtask

    task automatic test_backpressure();
        int r0   = rd_cnt;
        int base = got_q.size();
`ifdef FIFO_RD_STREAM_STATS_EN
        logic [31:0] w0 = stat_words_o;
        logic [31:0] s0 = stat_stall_o;
`endif
        m_ready_i = 1'b1;
        for (int i = 0; i < 16; i++) load(12'h200 + 12'(i));
        tick();
        tick();
        for (int k = 0; k < 30; k++) begin
            m_ready_i = !(k >= 5 && k < 15);
            #1;
            if (k >= 5 && k < 15) begin
                n_checks++;
                if (m_valid_o !== 1'b1 || m_data_o !== 12'h205) begin
                    n_fail++; $display("FAIL bp_stall_k%0d: got v=%b d=%h want v=1 d=205", k, m_valid_o, m_data_o);
                end
            end
            tick();
        end
        m_ready_i = 1'b1;
        n_checks++; if (got_q.size() - base !== 16) begin n_fail++; $display("FAIL bp_count: got %0d want 16", got_q.size() - base); end
        for (int i = 0; i < 16 && base + i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[base + i] !== 12'h200 + 12'(i)) begin
                n_fail++; $display("FAIL bp_order%0d: got %h want %h", i, got_q[base + i], 12'h200 + 12'(i));
            end
        end
        n_checks++; if (rd_cnt - r0 !== 16) begin n_fail++; $display("FAIL bp_rd_pulses: got %0d want 16", rd_cnt - r0); end
        n_checks++; if (ovf_cnt !== 0) begin n_fail++; $display("FAIL bp_occupancy: got %0d overfill cycles want 0", ovf_cnt); end
        n_checks++; if (bad_reads !== 0) begin n_fail++; $display("FAIL bp_read_empty: got %0d want 0", bad_reads); end
`ifdef FIFO_RD_STREAM_STATS_EN
        n_checks++; if (stat_stall_o - s0 !== 32'd10) begin n_fail++; $display("FAIL bp_stat_stall: got %0d want 10", stat_stall_o - s0); end
        n_checks++; if (stat_words_o - w0 !== 32'd16) begin n_fail++; $display("FAIL bp_stat_words: got %0d want 16", stat_words_o - w0); end
`endif
        $display("test_backpressure done");
    endtask

    task automatic test_flush();
        int base = got_q.size();
        m_ready_i = 1'b0;
        for (int i = 0; i < 6; i++) load(12'h300 + 12'(i));
        tick();
        tick();
        n_checks++; if (m_valid_o !== 1'b1 || m_data_o !== 12'h300) begin n_fail++; $display("FAIL flush_pre: got v=%b d=%h want v=1 d=300", m_valid_o, m_data_o); end
        flush_i = 1'b1;
        #1;
        n_checks++; if (fifo_rd_en_o !== 1'b0) begin n_fail++; $display("FAIL flush_rd_en: got %b want 0", fifo_rd_en_o); end
        tick();
        flush_i = 1'b0;
        n_checks++; if (m_valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b want 0", m_valid_o); end
        m_ready_i = 1'b1;
        tick();
        n_checks++; if (m_valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_refill_valid: got %b want 0", m_valid_o); end
        for (int i = 2; i < 6; i++) begin
            tick();
            n_checks++;
            if (m_valid_o !== 1'b1 || m_data_o !== 12'h300 + 12'(i)) begin
                n_fail++; $display("FAIL flush_word%0d: got v=%b d=%h want v=1 d=%h", i, m_valid_o, m_data_o, 12'h300 + 12'(i));
            end
        end
        tick();
        n_checks++; if (m_valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_end_valid: got %b want 0", m_valid_o); end
        n_checks++; if (got_q.size() - base !== 4) begin n_fail++; $display("FAIL flush_count: got %0d want 4", got_q.size() - base); end
        $display("test_flush done");
    endtask

    task automatic test_underflow();
        n_checks++; if (err_underflow_o !== 1'b0) begin n_fail++; $display("FAIL uf_before: got %b want 0", err_underflow_o); end
        fifo_underflow_i = 1'b1;
        tick();
        fifo_underflow_i = 1'b0;
        n_checks++; if (err_underflow_o !== 1'b1) begin n_fail++; $display("FAIL uf_set: got %b want 1", err_underflow_o); end
        repeat (5) tick();
        n_checks++; if (err_underflow_o !== 1'b1) begin n_fail++; $display("FAIL uf_sticky: got %b want 1", err_underflow_o); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (err_underflow_o !== 1'b0) begin n_fail++; $display("FAIL uf_async_clear: got %b want 0", err_underflow_o); end
        n_checks++; if (m_data_o !== 12'h000) begin n_fail++; $display("FAIL uf_reset_data: got %h want 000", m_data_o); end
`ifdef FIFO_RD_STREAM_STATS_EN
        n_checks++; if (stat_words_o !== 32'd0) begin n_fail++; $display("FAIL uf_reset_stat_words: got %0d want 0", stat_words_o); end
`endif
        tick();
        rst_n = 1'b1;
        tick();
        n_checks++; if (err_underflow_o !== 1'b0) begin n_fail++; $display("FAIL uf_after_reset: got %b want 0", err_underflow_o); end
        $display("test_underflow done");
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_stream();
        test_backpressure();
        test_flush();
        test_underflow();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
